w_sched_ctrl: RTL and testbench

//  Sequencer for the 64-word SHA-256 message-schedule expander (w64). Accepts one 512-bit

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/w64.sv | 59 +++++
 rtl/w_sched_ctrl.sv | 127 ++++++++++++
 tb/tb_w_sched_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 schedule constants, controller state encoding and sigma helpers
package sha256_pkg;

    localparam int W_LENGTH = 64;
    localparam int BLOCK_W  = 512;
    localparam int IDX_W    = $clog2(W_LENGTH);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // small sigma 0 of the message schedule
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // small sigma 1 of the message schedule
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

endpackage

// File: rtl/w64.sv
// rtl/w64.sv - 64-word SHA-256 message-schedule expander with one-cycle read latency
module w64
    import sha256_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [IDX_W-1:0]   index,
    input  logic               index_complete,
    input  logic [BLOCK_W-1:0] msg,
    output logic               complete,
    output logic [31:0]        cur_w
);

    // Every word is kept so that re-presenting an index recomputes the same value.
    logic [31:0] w_mem [W_LENGTH];
    logic [31:0] msg_words [16];
    logic [31:0] w_next;

    // split the block into big-endian words
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            msg_words[k] = msg[BLOCK_W-1-32*k -: 32];
        end
    end

    // word for the presented index: message word or schedule recurrence
    always_comb begin
        w_next = '0;
        if (index < IDX_W'(16)) begin
            w_next = msg_words[index[3:0]];
        end else begin
            w_next = ssig1(w_mem[index - IDX_W'(2)]) + w_mem[index - IDX_W'(7)]
                   + ssig0(w_mem[index - IDX_W'(15)]) + w_mem[index - IDX_W'(16)];
        end
    end

    // schedule storage; written while active, frozen after completion
    always_ff @(posedge clock) begin
        if (enable && !complete) begin
            w_mem[index] <= w_next;
        end
    end

    // output word and completion flag; enable low clears them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_w    <= '0;
            complete <= 1'b0;
        end else if (!enable) begin
            cur_w    <= '0;
            complete <= 1'b0;
        end else if (!complete) begin
            cur_w    <= w_next;
            complete <= index_complete;
        end
    end

endmodule

// File: rtl/w_sched_ctrl.sv
// rtl/w_sched_ctrl.sv - sequencer driving the w64 expander and streaming W[t] to the round engine
module w_sched_ctrl
    import sha256_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               sched_enable,
    output logic [IDX_W-1:0]   sched_index,
    output logic               sched_index_complete,
    output logic [BLOCK_W-1:0] sched_msg,
    input  logic               sched_complete,
    input  logic [31:0]        sched_cur_w,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [31:0]        w_word,
    output logic [IDX_W-1:0]   w_round,
    output logic               block_done
);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [IDX_W-1:0]   nxt_idx_q;
    logic [IDX_W-1:0]   w_round_q;
    logic               w_valid_q;
    logic [BLOCK_W-1:0] msg_q;
    logic               advance;
    logic               accept;

    // A new index may be issued when the output slot is empty or being accepted.
    assign advance = !w_valid_q || w_ready;
    assign accept  = blk_valid && blk_ready;

    assign sched_msg = msg_q;
    assign w_valid   = w_valid_q;
    assign w_round   = w_round_q;
    assign w_word    = sched_cur_w;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (advance && nxt_idx_q == LAST_IDX) state_d = DRAIN;
            DRAIN:   if (w_valid_q && w_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs; a stalled RUN re-presents the displayed round so the expander holds that word
    always_comb begin
        blk_ready            = 1'b0;
        sched_enable         = 1'b0;
        sched_index_complete = 1'b0;
        block_done           = 1'b0;
        sched_index          = nxt_idx_q;
        case (state_q)
            IDLE: begin
                // wait for the expander to report it is cleared before taking a block
                blk_ready = !sched_complete;
            end
            RUN: begin
                sched_enable = 1'b1;
                if (!advance) begin
                    sched_index = w_round_q;
                end
            end
            DRAIN: begin
                sched_enable         = 1'b1;
                sched_index_complete = 1'b1;
            end
            DONE: begin
                block_done = 1'b1;
            end
            default: ;
        endcase
    end

    // datapath: block latch, index counter and output slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msg_q     <= '0;
            nxt_idx_q <= '0;
            w_round_q <= '0;
            w_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        msg_q     <= blk_data;
                        nxt_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        w_valid_q <= 1'b1;
                        w_round_q <= nxt_idx_q;
                        if (nxt_idx_q != LAST_IDX) begin
                            nxt_idx_q <= nxt_idx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_valid_q && w_ready) begin
                        w_valid_q <= 1'b0;
                        w_round_q <= '0;
                        nxt_idx_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w_sched_ctrl.sv
// tb/tb_w_sched_ctrl.sv - self-checking bench for w_sched_ctrl driving a w64 expander
module tb_w_sched_ctrl;
    import sha256_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               blk_valid;
    logic               blk_ready;
    logic [BLOCK_W-1:0] blk_data;
    logic               sched_enable;
    logic [IDX_W-1:0]   sched_index;
    logic               sched_index_complete;
    logic [BLOCK_W-1:0] sched_msg;
    logic               sched_complete;
    logic [31:0]        sched_cur_w;
    logic               w_valid;
    logic               w_ready;
    logic [31:0]        w_word;
    logic [IDX_W-1:0]   w_round;
    logic               block_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int ready_bad = 0;

    logic [31:0] mw [64];
    logic [31:0] exp_q [$];
    logic [5:0]  got_r [$];
    logic [31:0] got_w [$];

    always #5 clock = ~clock;

    w64 u_w64 (
        .clock          (clock),
        .reset          (reset),
        .enable         (sched_enable),
        .index          (sched_index),
        .index_complete (sched_index_complete),
        .msg            (sched_msg),
        .complete       (sched_complete),
        .cur_w          (sched_cur_w)
    );

    w_sched_ctrl u_dut (
        .clock                (clock),
        .reset                (reset),
        .blk_valid            (blk_valid),
        .blk_ready            (blk_ready),
        .blk_data             (blk_data),
        .sched_enable         (sched_enable),
        .sched_index          (sched_index),
        .sched_index_complete (sched_index_complete),
        .sched_msg            (sched_msg),
        .sched_complete       (sched_complete),
        .sched_cur_w          (sched_cur_w),
        .w_valid              (w_valid),
        .w_ready              (w_ready),
        .w_word               (w_word),
        .w_round              (w_round),
        .block_done           (block_done)
    );

    // record accepted words and block_done pulses between edges
    always @(negedge clock) begin
        if (reset && w_valid && w_ready) begin
            got_r.push_back(w_round);
            got_w.push_back(w_word);
        end
        if (block_done) done_cnt++;
        if (blk_ready && (sched_enable || w_valid || block_done)) ready_bad++;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model_block(input logic [511:0] m, input bit push);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int t = 0; t < 16; t++) mw[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
            s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
            mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
        end
        if (push) for (int t = 0; t < 64; t++) exp_q.push_back(mw[t]);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_blk_ready"}, 64'(blk_ready), 64'd1);
        check({tag, "_enable"}, 64'(sched_enable), 64'd0);
        check({tag, "_index"}, 64'(sched_index), 64'd0);
        check({tag, "_idx_cplt"}, 64'(sched_index_complete), 64'd0);
        check({tag, "_msg_zero"}, 64'(sched_msg == '0), 64'd1);
        check({tag, "_w_valid"}, 64'(w_valid), 64'd0);
        check({tag, "_w_round"}, 64'(w_round), 64'd0);
        check({tag, "_block_done"}, 64'(block_done), 64'd0);
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_w.size()), 64'(exp_q.size()));
        n = (got_w.size() < exp_q.size()) ? got_w.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_round"}, 64'(got_r[i]), 64'(i % 64));
            check({tag, "_word"}, 64'(got_w[i]), 64'(exp_q[i]));
        end
        got_r.delete();
        got_w.delete();
        exp_q.delete();
    endtask

    // mode 0: always ready, 1: random ready, 2: stall sl cycles when round sr first shows
    task automatic run_block(input logic [511:0] m, input int mode, input int sr, input int sl,
                             output int cyc);
        bit stalled;
        int left;
        stalled = 1'b0;
        left    = 0;
        model_block(m, 1'b1);
        blk_data  = m;
        blk_valid = 1'b1;
        check("accept_ready", 64'(blk_ready), 64'd1);
        tick;
        blk_valid = 1'b0;
        cyc = 1;
        while (!block_done && cyc < 1000) begin
            if (mode == 2 && w_valid && int'(w_round) == sr && !stalled) begin
                stalled = 1'b1;
                left    = sl;
            end
            if (left > 0) begin
                w_ready = 1'b0;
                left--;
                check("stall_round", 64'(w_round), 64'(sr));
                check("stall_word", 64'(w_word), 64'(mw[sr]));
                if (sr == 63) check("drain_idx_cplt", 64'(sched_index_complete), 64'd1);
            end else if (mode == 1) begin
                w_ready = 1'($urandom_range(0, 1));
            end else begin
                w_ready = 1'b1;
            end
            tick;
            cyc++;
        end
        check("done_seen", 64'(block_done), 64'd1);
        w_ready = 1'b1;
        tick;
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] rb [3];
        int cyc;
        int d0;
        int n;
        int k;
        int done_at [3];

        abc = {32'h61626380, 448'd0, 32'h00000018};
        reset     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        repeat (3) tick;
        check_reset("reset");
        reset = 1'b1;
        tick;

        // abc block, always ready
        d0 = done_cnt;
        run_block(abc, 0, 0, 0, cyc);
        check("abc_done_cycle", 64'(cyc), 64'd66);
        check("abc_w0", 64'(got_w.size() > 0 ? got_w[0] : 32'hx), 64'h61626380);
        check("abc_w16", 64'(got_w.size() > 16 ? got_w[16] : 32'hx), 64'h61626380);
        check("abc_w63", 64'(got_w.size() > 63 ? got_w[63] : 32'hx), 64'h12B1EDEB);
        check("abc_one_done", 64'(done_cnt - d0), 64'd1);
        check_stream("abc");

        // abc block, 5-cycle stall at round 20
        d0 = done_cnt;
        run_block(abc, 2, 20, 5, cyc);
        check("stall20_done_cycle", 64'(cyc), 64'd71);
        check("stall20_one_done", 64'(done_cnt - d0), 64'd1);
        check_stream("stall20");

        // all-zero then random block under random backpressure
        d0 = done_cnt;
        run_block('0, 1, 0, 0, cyc);
        check("zero_one_done", 64'(done_cnt - d0), 64'd1);
        check_stream("zero_rand");
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 16; j++) rb[0][32*j +: 32] = $urandom;
            d0 = done_cnt;
            run_block(rb[0], 1, 0, 0, cyc);
            check("rand_one_done", 64'(done_cnt - d0), 64'd1);
            check_stream("rand");
        end

        // stall at round 63 while draining
        d0 = done_cnt;
        run_block(abc, 2, 63, 3, cyc);
        check("stall63_done_cycle", 64'(cyc), 64'd69);
        check("stall63_one_done", 64'(done_cnt - d0), 64'd1);
        check_stream("stall63");

        // three back-to-back blocks with blk_valid held high
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 16; j++) rb[b][32*j +: 32] = $urandom;
            model_block(rb[b], 1'b1);
        end
        d0 = done_cnt;
        ready_bad = 0;
        n = 0;
        cyc = 0;
        w_ready = 1'b1;
        blk_data = rb[0];
        blk_valid = 1'b1;
        while (n < 3 && cyc < 400) begin
            tick;
            cyc++;
            if (block_done) begin
                done_at[n] = cyc;
                n++;
                if (n < 3) blk_data = rb[n];
                else blk_valid = 1'b0;
            end
        end
        blk_valid = 1'b0;
        tick;
        check("b2b_done_count", 64'(done_cnt - d0), 64'd3);
        check("b2b_period1", 64'(done_at[1] - done_at[0]), 64'd67);
        check("b2b_period2", 64'(done_at[2] - done_at[1]), 64'd67);
        check("b2b_ready_only_idle", 64'(ready_bad), 64'd0);
        check_stream("b2b");

        // reset while round 30 is on the output
        for (int j = 0; j < 16; j++) rb[0][32*j +: 32] = $urandom;
        d0 = done_cnt;
        blk_data = rb[0];
        blk_valid = 1'b1;
        tick;
        blk_valid = 1'b0;
        w_ready = 1'b1;
        k = 0;
        while (!(w_valid && w_round == 6'd30) && k < 200) begin
            tick;
            k++;
        end
        check("rst_reach_round30", 64'(w_round), 64'd30);
        reset = 1'b0;
        #1;
        check_reset("midrst");
        tick;
        tick;
        reset = 1'b1;
        tick;
        tick;
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_partial_words", 64'(got_w.size()), 64'd30);
        got_r.delete();
        got_w.delete();
        d0 = done_cnt;
        run_block(rb[0], 1, 0, 0, cyc);
        check("post_rst_one_done", 64'(done_cnt - d0), 64'd1);
        check_stream("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
